// File: rtl/pmem_burst_adapter.sv
// pmem_burst_adapter: answers line-wide pmem read/write requests by running a
// fixed-length burst of narrow beats on the downstream memory port.
module pmem_burst_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [31:0]           burst_address,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  // Clears the byte-offset bits so the burst always starts on a line boundary.
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                           state, state_n;
  logic [BEAT_W-1:0]                beat;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_buf;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] wr_buf;
  logic                             last_beat;

  assign last_beat  = burst_resp && (beat == LAST_BEAT);
  assign pmem_rdata = line_buf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and state-decoded outputs; nothing here looks at pmem_* except
  // the IDLE acceptance decision, so burst_* never follow the requester directly.
  always_comb begin
    state_n     = state;
    pmem_resp   = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_wdata = '0;
    case (state)
      IDLE: begin
        if (pmem_read)       state_n = READ;
        else if (pmem_write) state_n = WRITE;
      end
      READ: begin
        burst_read = 1'b1;
        if (last_beat) state_n = DONE;
      end
      WRITE: begin
        burst_write = 1'b1;
        burst_wdata = wr_buf[beat];
        if (last_beat) state_n = DONE;
      end
      DONE: begin
        pmem_resp = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Beat counter, burst address and line buffer. The read buffer is cleared by
  // reset because pmem_rdata exposes it directly; the write staging buffer is
  // only ever observed while WRITE is active, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat          <= '0;
      line_buf      <= '0;
      burst_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            beat          <= '0;
            burst_address <= pmem_address & LINE_MASK;
          end
        end
        READ: begin
          if (burst_resp) begin
            line_buf[beat] <= burst_rdata;
            beat           <= beat + BEAT_W'(1);
          end
        end
        WRITE: begin
          if (burst_resp) beat <= beat + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Write line capture at acceptance; a simultaneous read takes priority, so
  // the write data is captured later when the write itself is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && !pmem_read && pmem_write) wr_buf <= pmem_wdata;
  end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Bench for pmem_burst_adapter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the adapter.
module tb_pmem_burst_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pmem_read = 1'b0;
  logic          pmem_write = 1'b0;
  logic [31:0]   pmem_address = '0;
  logic [LW-1:0] pmem_wdata = '0;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          burst_read;
  logic          burst_write;
  logic [31:0]   burst_address;
  logic [BW-1:0] burst_wdata;
  logic [BW-1:0] burst_rdata;
  logic          burst_resp;

  // Downstream responder: either scripted by the main sequence or random.
  bit            auto_drv = 1'b0;
  int            resp_pct = 100;
  logic          man_resp = 1'b0;
  logic [BW-1:0] man_rdata = '0;
  logic          auto_resp = 1'b0;
  logic [BW-1:0] auto_rdata = '0;

  assign burst_resp  = auto_drv ? auto_resp  : man_resp;
  assign burst_rdata = auto_drv ? auto_rdata : man_rdata;

  always #5 clk = ~clk;

  pmem_burst_adapter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always @(negedge clk) begin
    auto_resp  = ($urandom_range(99) < resp_pct);
    auto_rdata = {$urandom, $urandom};
  end

  int n_checks = 0;
  int n_fail   = 0;
  int resp_count = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: which job is in flight, how many beats of it have
  // moved, and what line memory holds.
  int            m_job = 0;   // 0 none, 1 read line, 2 write line, 3 completing
  int            m_done = 0;  // beats transferred in current job
  logic [31:0]   m_addr = '0;
  logic [BW-1:0] m_line [NB];
  logic [BW-1:0] m_wline [NB];

  function automatic logic [LW-1:0] m_flat();
    logic [LW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*BW +: BW] = m_line[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_job = 0; m_done = 0; m_addr = '0;
      for (int i = 0; i < NB; i++) m_line[i] = '0;
    end else if (m_job == 0) begin
      if (pmem_read || pmem_write) begin
        m_addr = {pmem_address[31:5], 5'b0};
        m_done = 0;
        m_job  = pmem_read ? 1 : 2;
        if (!pmem_read)
          for (int i = 0; i < NB; i++) m_wline[i] = pmem_wdata[i*BW +: BW];
      end
    end else if (m_job == 3) begin
      m_job = 0;
    end else if (burst_resp) begin
      if (m_job == 1) m_line[m_done[1:0]] = burst_rdata;
      m_done++;
      if (m_done == NB) m_job = 3;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pmem_resp",   LW'(pmem_resp),   LW'(m_job == 3));
      chk("burst_read",  LW'(burst_read),  LW'(m_job == 1));
      chk("burst_write", LW'(burst_write), LW'(m_job == 2));
      chk("pmem_rdata",  pmem_rdata,       m_flat());
      if (m_job == 1 || m_job == 2) chk("burst_address", LW'(burst_address), LW'(m_addr));
      if (m_job == 2) chk("burst_wdata", LW'(burst_wdata), LW'(m_wline[m_done[1:0]]));
      if (pmem_resp) resp_count++;
    end
  end

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pmem_resp) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout at %0t: got no pmem_resp expected pulse within 400 cycles", $time);
    end
  endtask

  task automatic do_xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [LW-1:0] wd);
    bit ok;
    @(negedge clk);
    pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = wd;
    wait_resp(ok);
    if (rd && wr) begin
      pmem_read = 1'b0;
      if (ok) wait_resp(ok);
    end
    pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = $urandom; pmem_wdata = {8{$urandom}};
  endtask

  logic [BW-1:0] rb [NB];
  logic [BW-1:0] wd [NB];
  logic [LW-1:0] saved;
  logic [1:0]    idx;
  int            rc0;

  initial begin
    rb[0] = {8{8'h11}}; rb[1] = {8{8'h22}}; rb[2] = {8{8'h33}}; rb[3] = {8{8'h44}};
    wd[0] = 64'h0123_4567_89AB_CDEF; wd[1] = 64'hFEDC_BA98_7654_3210;
    wd[2] = 64'hDEAD_BEEF_0000_0001; wd[3] = 64'h8000_0000_CAFE_F00D;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pmem_resp",   LW'(pmem_resp),     '0);
    chk("rst_burst_read",  LW'(burst_read),    '0);
    chk("rst_burst_write", LW'(burst_write),   '0);
    chk("rst_burst_addr",  LW'(burst_address), '0);
    chk("rst_burst_wdata", LW'(burst_wdata),   '0);
    chk("rst_pmem_rdata",  pmem_rdata,         '0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Read without stalls at 0x1234
    pmem_read = 1'b1; pmem_address = 32'h0000_1234;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rd_burst_read", LW'(burst_read), LW'(1'b1));
        chk("rd_burst_addr", LW'(burst_address), LW'(32'h0000_1220));
      end
      chk("rd_no_early_resp", LW'(pmem_resp), '0);
      man_resp = 1'b1; man_rdata = rb[i];
    end
    @(negedge clk);
    chk("rd_resp", LW'(pmem_resp), LW'(1'b1));
    chk("rd_line", pmem_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    man_resp = 1'b0; pmem_read = 1'b0;
    @(negedge clk);
    chk("rd_resp_single", LW'(pmem_resp), '0);

    // Write with resp on every other cycle
    pmem_write = 1'b1; pmem_address = 32'h0000_0040; pmem_wdata = {wd[3], wd[2], wd[1], wd[0]};
    for (int k = 0; k < 2 * NB; k++) begin
      @(negedge clk);
      idx = 2'(k / 2);
      chk("wr_burst_write", LW'(burst_write), LW'(1'b1));
      chk("wr_beat_order", LW'(burst_wdata), LW'(wd[idx]));
      if (k == 0) chk("wr_burst_addr", LW'(burst_address), LW'(32'h0000_0040));
      man_resp = k[0];
    end
    @(negedge clk);
    chk("wr_resp", LW'(pmem_resp), LW'(1'b1));
    man_resp = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    chk("wr_write_low", LW'(burst_write), '0);
    chk("wr_resp_single", LW'(pmem_resp), '0);
    chk("wr_rdata_kept", pmem_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});

    // Reset in the middle of a read after two beats
    pmem_read = 1'b1; pmem_address = 32'h0000_0080;
    @(negedge clk); man_resp = 1'b1; man_rdata = {8{8'hAA}};
    @(negedge clk); man_rdata = {8{8'hBB}};
    @(negedge clk); man_resp = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; pmem_read = 1'b0;
    chk("rst_mid_burst_read", LW'(burst_read), '0);
    chk("rst_mid_pmem_resp",  LW'(pmem_resp),  '0);
    chk("rst_mid_rdata",      pmem_rdata,      '0);
    auto_drv = 1'b1; resp_pct = 60;
    do_xfer(1'b1, 1'b0, 32'h0000_0100, '0);

    // Stray downstream responses while idle
    resp_pct = 100;
    repeat (8) begin
      @(negedge clk);
      chk("stray_resp", LW'(pmem_resp), '0);
      chk("stray_read", LW'(burst_read), '0);
    end

    // Simultaneous read and write: two completions
    rc0 = resp_count;
    do_xfer(1'b1, 1'b1, 32'h0000_2000, {8{32'h5A5A_1234}});
    repeat (2) @(negedge clk);
    chk("both_two_resps", LW'(resp_count - rc0), LW'(2));

    // Back-to-back reads with the request held through the response
    @(negedge clk);
    pmem_read = 1'b1; pmem_address = 32'h0000_3000;
    begin
      bit ok;
      wait_resp(ok);
      saved = m_flat();
      pmem_address = 32'h0000_4020;
      @(negedge clk);
      chk("b2b_gap", LW'(burst_read), '0);
      @(negedge clk);
      chk("b2b_second_read", LW'(burst_read), LW'(1'b1));
      chk("b2b_second_addr", LW'(burst_address), LW'(32'h0000_4020));
      chk("b2b_rdata_hold", pmem_rdata, saved);
      wait_resp(ok);
      pmem_read = 1'b0;
    end

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      int op;
      int pick;
      pick = $urandom_range(2);
      resp_pct = (pick == 0) ? 100 : ((pick == 1) ? 50 : 20);
      repeat ($urandom_range(3)) @(negedge clk);
      op = $urandom_range(3);
      do_xfer(op != 1, op != 0, $urandom, {$urandom, $urandom, $urandom, $urandom,
                                           $urandom, $urandom, $urandom, $urandom});
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
